// File: rtl/acquisition_controller.sv
// Acquisition sequencer: arms capture, forwards external triggers as capture strobes,
// then drains NUM_BYTES bytes from the capture buffer into a valid/ready byte sink.
module acquisition_controller #(
  parameter int unsigned NUM_BYTES      = 1024,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ArmRequest,
  input  logic [7:0] NumTriggers,
  input  logic       TriggerIn,
  output logic       CaptureStrobe,
  input  logic       StorageDataReady,
  input  logic [7:0] StorageData,
  output logic       StorageReadEnable,
  output logic [7:0] TxData,
  output logic       TxValid,
  input  logic       TxReady,
  output logic       Busy,
  output logic       Done,
  output logic       TimedOut
);

  typedef enum logic [2:0] {
    IDLE, ARMED, WAIT_READY, LOAD, SEND, ADVANCE, SETTLE
  } state_t;

  localparam logic [10:0] LAST_BYTE   = 11'(NUM_BYTES);
  localparam logic        TIMEOUT_EN  = (TIMEOUT_CYCLES != 24'd0);
  localparam logic [23:0] TIMEOUT_MAX = TIMEOUT_CYCLES - 24'd1;

  state_t      state_q, state_d;
  logic [7:0]  trig_count_q, trig_count_d;
  logic [10:0] byte_count_q, byte_count_d;
  logic [23:0] timer_q, timer_d;
  logic        settle_q, settle_d;
  logic        capture_q, capture_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        done_q, done_d;
  logic        trig_prev_q;

  logic trig_edge;
  logic waiting;
  logic timeout_hit;
  logic accept;

  assign trig_edge   = TriggerIn & ~trig_prev_q;
  assign waiting     = (state_q == ARMED) || (state_q == WAIT_READY);
  // Fires during the TIMEOUT_CYCLES-th cycle spent waiting; the abort lands next cycle.
  assign timeout_hit = TIMEOUT_EN && waiting && (timer_q == TIMEOUT_MAX);
  assign accept      = tx_valid_q & TxReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      trig_count_q <= 8'd0;
      byte_count_q <= 11'd0;
      timer_q      <= 24'd0;
      settle_q     <= 1'b0;
      capture_q    <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_count_q <= trig_count_d;
      byte_count_q <= byte_count_d;
      timer_q      <= timer_d;
      settle_q     <= settle_d;
      capture_q    <= capture_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      done_q       <= done_d;
    end
  end

  // The edge detector tracks the input in every state so a level held across arming is ignored.
  always_ff @(posedge Clock) begin
    trig_prev_q <= TriggerIn;
  end

  always_comb begin
    state_d      = state_q;
    trig_count_d = trig_count_q;
    byte_count_d = byte_count_q;
    timer_d      = timer_q;
    settle_d     = settle_q;
    capture_d    = 1'b0;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (ArmRequest) begin
          trig_count_d = (NumTriggers == 8'd0) ? 8'd1 : NumTriggers;
          byte_count_d = 11'd0;
          timer_d      = 24'd0;
          state_d      = ARMED;
        end
      end
      ARMED: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else begin
          if (TIMEOUT_EN) timer_d = timer_q + 24'd1;
          if (trig_edge && (trig_count_q != 8'd0)) begin
            capture_d    = 1'b1;
            trig_count_d = trig_count_q - 8'd1;
            if (trig_count_q == 8'd1) state_d = WAIT_READY;
          end
        end
      end
      WAIT_READY: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (StorageDataReady) begin
          state_d = LOAD;
        end else if (TIMEOUT_EN) begin
          timer_d = timer_q + 24'd1;
        end
      end
      LOAD: begin
        tx_data_d  = StorageData;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (accept) begin
          tx_valid_d   = 1'b0;
          byte_count_d = byte_count_q + 11'd1;
          if (byte_count_q + 11'd1 == LAST_BYTE) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ADVANCE;
          end
        end
      end
      ADVANCE: begin
        settle_d = 1'b0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        // Two cycles: buffer updates its byte select, then its output register.
        if (settle_q) begin
          settle_d = 1'b0;
          state_d  = LOAD;
        end else begin
          settle_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy              = (state_q != IDLE);
    StorageReadEnable = (state_q == ADVANCE);
    TimedOut          = timeout_hit;
    CaptureStrobe     = capture_q;
    TxData            = tx_data_q;
    TxValid           = tx_valid_q;
    Done              = done_q;
  end

endmodule

// File: doc/acquisition_controller.md
# acquisition_controller

Single-clock sequencer for the accumulating capture buffer. Arms capture, forwards a programmed number of external triggers to the buffer as single-cycle capture strobes, and waits for the buffer to report data ready. It then drains exactly NUM_BYTES bytes from the buffer's byte-serial read port into a valid/ready byte sink (the UART transmit path), and reports completion or timeout to the host command decoder.

## Interface
Parameters:
- NUM_BYTES, 1024: bytes drained per acquisition (512 points x 2 bytes); range 2..2047.
- TIMEOUT_CYCLES, 24'd10_000_000: cycles allowed in ARMED or WAIT_READY before abort; 0 disables the timeout.

Ports:
- Clock  in  1  sole clock; also the buffer read clock.
- Reset  in  1  synchronous, active-high.
- ArmRequest  in  1  single-cycle arm command; ignored unless in IDLE.
- NumTriggers  in  8  triggers to accumulate; sampled on accepted ArmRequest; 0 treated as 1.
- TriggerIn  in  1  external trigger, already synchronised to Clock; rising edge counts.
- CaptureStrobe  out  1  one-cycle capture pulse to the buffer.
- StorageDataReady  in  1  buffer has data to drain.
- StorageData  in  8  buffer byte output; registered by the buffer.
- StorageReadEnable  out  1  one-cycle advance pulse to the buffer.
- TxData  out  8  byte to sink.
- TxValid  out  1  TxData valid.
- TxReady  in  1  sink accepts when TxValid & TxReady.
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  one-cycle pulse when the last byte is accepted.
- TimedOut  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, ARMED, WAIT_READY, LOAD, SEND, ADVANCE, SETTLE.
- IDLE: ArmRequest -> latch max(NumTriggers,1) into trigCount; clear byteCount and timer -> ARMED.
- ARMED: a TriggerIn rising edge (TriggerIn high, previous sample low) issues CaptureStrobe on the next cycle and decrements trigCount. When the decrement reaches 0 -> WAIT_READY. The edge detector is updated in every state, so a trigger held high from before arming does not count.
- WAIT_READY: StorageDataReady high -> LOAD.
- LOAD: TxData <= StorageData, TxValid <= 1 -> SEND.
- SEND: hold TxData/TxValid stable until TxValid & TxReady. On accept: TxValid <= 0, byteCount+1.
  - If the new count == NUM_BYTES -> Done pulse -> IDLE, with no StorageReadEnable.
  - Else -> ADVANCE.
- ADVANCE: StorageReadEnable high for exactly this cycle -> SETTLE.
- SETTLE: wait 2 cycles (the buffer updates its byte select, then its output register) -> LOAD. StorageDataReady is not re-checked mid-transfer.
- Timeout: timer counts cycles spent in ARMED plus WAIT_READY and clears on entering ARMED. Reaching TIMEOUT_CYCLES -> TimedOut pulse, -> IDLE. CaptureStrobes already issued are not undone.
- byteCount is 11 bits and never wraps within an acquisition. trigCount is 8 bits and never underflows.
- ArmRequest outside IDLE: ignored, no side effect.

## Timing
- Reset values: CaptureStrobe 0, StorageReadEnable 0, TxValid 0, TxData 8'h00, Busy 0, Done 0, TimedOut 0, state IDLE, all counters 0.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. An in-flight TxValid drops immediately.
- ArmRequest at cycle n -> Busy high at n+1.
- TriggerIn rises at cycle n (sampled) -> CaptureStrobe high at n+1.
  - Back-to-back triggers need TriggerIn low for at least 1 cycle between edges.
  - Maximum strobe rate is one per 2 cycles.
- StorageDataReady sampled at n in WAIT_READY -> TxValid high at n+2.
- Byte pipeline, with accept at cycle a: StorageReadEnable at a+1, SETTLE a+2..a+3, LOAD a+4, next TxValid at a+5. Minimum 5 cycles per byte with TxReady held high.
- Done is asserted in the cycle after the final accept; Busy falls in that same cycle.
- Done and TimedOut are never asserted together.
- If Reset and ArmRequest arrive together, Reset wins.

## Test plan
- Reset, then ArmRequest with NumTriggers=3 and 3 TriggerIn pulses (2 cycles high, 4 low) -> exactly 3 CaptureStrobe pulses, each 1 cycle after its rising edge; state WAIT_READY, Busy=1.
- NumTriggers=0, one trigger, StorageDataReady high, TxReady tied high, buffer model returns an incrementing byte -> exactly 1024 TxValid&TxReady accepts with values 0..1023 mod 256, 1023 StorageReadEnable pulses, Done once, 5-cycle byte spacing.
- Same as above with TxReady randomly low 50% -> TxData stable while TxValid & !TxReady, no byte lost or duplicated, 1024 accepts.
- TIMEOUT_CYCLES=100, arm, no trigger -> TimedOut at exactly cycle 100 after arm, Busy low next cycle, no Done.
- Reset asserted at byte 500 of a drain -> all outputs 0 next cycle; subsequent arm/drain completes 1024 bytes normally.
- ArmRequest pulsed during SEND and TriggerIn held high across arm -> no restart, no counter change, held trigger not counted until it falls and rises again.
